// File: rtl/mealy_seq_pkg.sv
// Shared types and helpers for the run-time configurable Mealy sequence detector.
package mealy_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // A zero length is treated as one bit; anything longer than the hardware holds is capped.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        int unsigned r;
        if (len == 32'd0) begin
            r = 32'd1;
        end else if (len > max_len) begin
            r = max_len;
        end else begin
            r = len;
        end
        return r;
    endfunction

    function automatic logic [31:0] len_mask(input int unsigned len);
        logic [31:0] m;
        if (len >= 32'd32) begin
            m = {32{1'b1}};
        end else begin
            m = (32'd1 << len) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_hist_shreg.sv
// History shift register and fill counter for the sequence detector.
module seq_hist_shreg #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               shift,
    input  logic               in,
    input  logic [LEN_W-1:0]   len,
    output logic [MAX_LEN-2:0] history,
    output logic [LEN_W-1:0]   fill_cnt,
    output logic               full
);

    logic [MAX_LEN-2:0] history_r;
    logic [LEN_W-1:0]   fill_cnt_r;
    logic [MAX_LEN-1:0] ext_s;
    logic               full_s;

    assign ext_s  = {history_r, in};
    assign full_s = (fill_cnt_r == (len - LEN_W'(1)));

    // Shift in the newest bit; the fill count stops once len-1 bits are held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history_r  <= {(MAX_LEN-1){1'b0}};
            fill_cnt_r <= {LEN_W{1'b0}};
        end else if (clear) begin
            history_r  <= {(MAX_LEN-1){1'b0}};
            fill_cnt_r <= {LEN_W{1'b0}};
        end else if (shift) begin
            history_r <= ext_s[MAX_LEN-2:0];
            if (!full_s) begin
                fill_cnt_r <= fill_cnt_r + LEN_W'(1);
            end
        end
    end

    assign history  = history_r;
    assign fill_cnt = fill_cnt_r;
    assign full     = full_s;

endmodule

// File: rtl/mealy_seq_detector.sv
// Run-time configurable Mealy serial pattern detector with saturating match counter.
// Define MEALY_SEQ_REG_OUT_EN to register `out` (one-cycle delayed single pulse).
module mealy_seq_detector
    import mealy_seq_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    output logic               out,
    output logic               armed,
    output logic               configured,
    output logic [CNT_W-1:0]   match_count
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic               configured_r;
    logic [CNT_W-1:0]   count_r;

    logic [LEN_W-1:0]   len_ld_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-2:0] history_s;
    logic [LEN_W-1:0]   fill_cnt_s;
    logic               full_s;
    logic               hit_s;
    logic               match_s;
    logic               armed_s;
    logic               clear_s;
    logic               shift_s;

    assign len_ld_s = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
    assign mask_s   = MAX_LEN'(len_mask(32'(len_r)));
    assign window_s = {history_s, in};
    assign hit_s    = (((window_s ^ pattern_r) & mask_s) == {MAX_LEN{1'b0}});

    // A non-overlapping match restarts the fill from empty history.
    assign clear_s  = cfg_load | (match_s & ~overlap_r);
    assign shift_s  = ~clear_s & in_valid & (state_r != IDLE);

    seq_hist_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear_s),
        .shift    (shift_s),
        .in       (in),
        .len      (len_r),
        .history  (history_s),
        .fill_cnt (fill_cnt_s),
        .full     (full_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a load overrides whatever the stream is doing.
    always_comb begin
        state_nxt_s = state_r;
        if (cfg_load) begin
            if (len_ld_s == LEN_W'(1)) begin
                state_nxt_s = ARMED;
            end else begin
                state_nxt_s = FILL;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                FILL: begin
                    if (in_valid && (fill_cnt_s == (len_r - LEN_W'(2)))) begin
                        state_nxt_s = ARMED;
                    end else begin
                        state_nxt_s = FILL;
                    end
                end
                ARMED: begin
                    if (match_s && !overlap_r && (len_r != LEN_W'(1))) begin
                        state_nxt_s = FILL;
                    end else begin
                        state_nxt_s = ARMED;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Output decode: the match is qualified by state, strobe and the absence of a load.
    always_comb begin
        armed_s = (state_r == ARMED);
        if (armed_s && in_valid && !cfg_load) begin
            match_s = hit_s;
        end else begin
            match_s = 1'b0;
        end
    end

    // Configuration capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_r    <= {MAX_LEN{1'b0}};
            len_r        <= {LEN_W{1'b0}};
            overlap_r    <= 1'b0;
            configured_r <= 1'b0;
        end else if (cfg_load) begin
            pattern_r    <= cfg_pattern;
            len_r        <= len_ld_s;
            overlap_r    <= cfg_overlap;
            configured_r <= 1'b1;
        end
    end

    // Saturating match counter, cleared on every load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (cfg_load) begin
            count_r <= {CNT_W{1'b0}};
        end else if (match_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

`ifdef MEALY_SEQ_REG_OUT_EN
    logic out_r;

    // One-cycle delayed match pulse; a load drops any pending pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r <= 1'b0;
        end else if (cfg_load) begin
            out_r <= 1'b0;
        end else begin
            out_r <= match_s;
        end
    end

    assign out = out_r;
`else
    assign out = match_s;
`endif

    assign armed       = armed_s;
    assign configured  = configured_r;
    assign match_count = count_r;

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Table-driven bench for mealy_seq_detector; a second instance with a 2-bit counter checks saturation.
module tb_mealy_seq_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
`ifdef MEALY_SEQ_REG_OUT_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_load;
    logic [7:0]       cfg_pattern;
    logic [3:0]       cfg_len;
    logic             cfg_overlap;
    logic             in_valid;
    logic             in;
    logic             out, out2;
    logic             armed, armed2;
    logic             configured, configured2;
    logic [7:0]       match_count;
    logic [1:0]       match_count2;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       v;
        logic       b;
        logic       eo;
        logic       ea;
        int         ec;
    } vec_t;

    vec_t tbl[$];
    logic prev_exp = 1'b0;

    always #5 clk = ~clk;

    mealy_seq_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
        .out(out), .armed(armed), .configured(configured), .match_count(match_count)
    );

    mealy_seq_detector #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in(in),
        .out(out2), .armed(armed2), .configured(configured2), .match_count(match_count2)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                       input logic v, input logic b, input logic eo, input logic ea, input int ec);
        vec_t r;
        r.ld = ld; r.pat = pat; r.len = len; r.ovl = ovl;
        r.v = v; r.b = b; r.eo = eo; r.ea = ea; r.ec = ec;
        tbl.push_back(r);
    endtask

    task automatic add_bit(input logic v, input logic b, input logic eo, input logic ea, input int ec);
        add(1'b0, 8'h00, 4'd0, 1'b0, v, b, eo, ea, ec);
    endtask

    initial begin
        logic exp_o;
        vec_t r;

        // scenario 1: 101 overlapping (upper pattern bits are don't-care)
        add(1'b1, 8'b1111_0101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 1);
        add_bit(1'b1, 1'b0, 1'b0, 1'b1, 1);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 2);
        // scenario 2: 101 non-overlapping
        add(1'b1, 8'b0000_0101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b0, 1);
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, 1);
        add_bit(1'b1, 1'b1, 1'b0, 1'b1, 1);
        // scenario 3: len 1 with gaps in in_valid
        add(1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 1);
        add_bit(1'b0, 1'b1, 1'b0, 1'b1, 1);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 2);
        add_bit(1'b0, 1'b0, 1'b0, 1'b1, 2);
        add_bit(1'b1, 1'b0, 1'b0, 1'b1, 2);
        add_bit(1'b0, 1'b1, 1'b0, 1'b1, 2);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 3);
        // len 0 clamps to 1 (pattern bit 0 = 0)
        add(1'b1, 8'b0000_0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b0, 1'b1, 1'b1, 1);
        add_bit(1'b1, 1'b1, 1'b0, 1'b1, 1);
        // len 15 clamps to 8, pattern A5
        add(1'b1, 8'hA5, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 1);
        // scenario 4: 11 overlapping, six 1s (second instance saturates at 3)
        add(1'b1, 8'b0000_0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 1);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 2);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 3);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 4);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 5);
        // scenario 5: reload mid-stream while a match would otherwise fire
        add(1'b1, 8'b0000_0110, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b1, 0);
        add(1'b1, 8'b0000_0011, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b0, 1'b0, 1'b0, 0);
        add_bit(1'b1, 1'b1, 1'b0, 1'b1, 0);
        add_bit(1'b1, 1'b1, 1'b1, 1'b1, 1);

        reset_n = 1'b0; cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
        cfg_overlap = 1'b0; in_valid = 1'b0; in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_armed", 0, 32'(armed), 32'd0);
        chk("reset_configured", 0, 32'(configured), 32'd0);
        chk("reset_count", 0, 32'(match_count), 32'd0);
        chk("reset_out", 0, 32'(out), 32'd0);
        reset_n = 1'b1;

        // unconfigured: input ignored
        in_valid = 1'b1; in = 1'b1;
        #3;
        chk("idle_out", 0, 32'(out), 32'd0);
        @(posedge clk); #1;
        chk("idle_armed", 0, 32'(armed), 32'd0);
        chk("idle_configured", 0, 32'(configured), 32'd0);
        chk("idle_count", 0, 32'(match_count), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            cfg_load = r.ld; cfg_pattern = r.pat; cfg_len = r.len; cfg_overlap = r.ovl;
            in_valid = r.v; in = r.b;
            #3;
            exp_o = REG ? prev_exp : r.eo;
            chk("out", i, 32'(out), 32'(exp_o));
            chk("out_cnt2", i, 32'(out2), 32'(exp_o));
            prev_exp = r.eo;
            @(posedge clk); #1;
            cfg_load = 1'b0;
            chk("armed", i, 32'(armed), 32'(r.ea));
            chk("armed_cnt2", i, 32'(armed2), 32'(r.ea));
            chk("configured", i, 32'(configured), 32'd1);
            chk("count", i, 32'(match_count), 32'(r.ec));
            chk("count_sat", i, 32'(match_count2), (r.ec > 3) ? 32'd3 : 32'(r.ec));
        end

        // scenario 6: asynchronous reset mid-cycle after a few bits
        cfg_load = 1'b1; cfg_pattern = 8'b0000_0101; cfg_len = 4'd3; cfg_overlap = 1'b1;
        in_valid = 1'b0; in = 1'b0;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        in_valid = 1'b1; in = 1'b1;
        @(posedge clk); #1;
        in = 1'b0;
        @(posedge clk); #1;
        in = 1'b1;
        #3;
        chk("pre_reset_out", 100, 32'(out), REG ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        chk("pre_reset_count", 100, 32'(match_count), 32'd1);
        in = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_armed", 101, 32'(armed), 32'd0);
        chk("async_configured", 101, 32'(configured), 32'd0);
        chk("async_count", 101, 32'(match_count), 32'd0);
        chk("async_out", 101, 32'(out), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in = k[0];
            #3;
            chk("post_reset_out", 102 + k, 32'(out), 32'd0);
            @(posedge clk); #1;
            chk("post_reset_armed", 102 + k, 32'(armed), 32'd0);
            chk("post_reset_count", 102 + k, 32'(match_count), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
